// File: rtl/child_rr_scheduler_pkg.sv
// Shared types and defaults for the child round-robin scheduler.
package child_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  localparam int unsigned DefNumReq  = 5;
  localparam int unsigned DefMaxHold = 16;
  localparam int unsigned DefCntW    = 8;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/child_rr_scheduler_if.sv
// Request/grant bundle between the child instances (master) and the scheduler (slave).
interface child_rr_scheduler_if
  import child_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned IdxW    = idx_w(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       gnt;
  logic                     gnt_valid;
  logic [IdxW-1:0]          gnt_idx;
  logic                     revoked;
  logic [NUM_REQ*CNT_W-1:0] gnt_cnt;

  modport master (
    output req, done,
    input  gnt, gnt_valid, gnt_idx, revoked, gnt_cnt
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, gnt_idx, revoked, gnt_cnt
  );

endinterface

// File: rtl/child_rr_scheduler_rr_pick.sv
// Combinational rotate-priority picker: first requester strictly after last_idx_i, wrapping.
module child_rr_scheduler_rr_pick
  import child_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned IdxW    = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_idx_i,
  output logic [IdxW-1:0]    next_idx_o,
  output logic               found_o
);

  int unsigned cand;

  always_comb begin
    found_o    = 1'b0;
    next_idx_o = last_idx_i;
    cand       = 0;
    // Offset NUM_REQ lands back on last_idx_i, so a lone requester can be re-granted.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_idx_i) + k) % NUM_REQ;
      if (!found_o && req_i[cand]) begin
        found_o    = 1'b1;
        next_idx_o = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/child_rr_scheduler.sv
// Round-robin grant of one shared resource among NUM_REQ children, with per-child grant counters.
// Optional forced revoke after MAX_HOLD cycles when SCHED_TIMEOUT_EN is defined.
module child_rr_scheduler
  import child_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DefNumReq,
  parameter int unsigned MAX_HOLD = DefMaxHold,
  parameter int unsigned CNT_W    = DefCntW
) (
  input logic                 clk,
  input logic                 rst,
  child_rr_scheduler_if.slave bus
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);

  typedef logic [IdxW-1:0]    idx_t;
  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD == 0) begin : gen_bad_cfg
    $error("child_rr_scheduler: unsupported NUM_REQ/MAX_HOLD");
  end

  state_e state_q, state_d;
  req_t   gnt_q, gnt_d;
  logic   gnt_valid_q, gnt_valid_d;
  idx_t   gnt_idx_q, gnt_idx_d;
  logic   revoked_q, revoked_d;
  cnt_t   cnt_q [NUM_REQ];
  cnt_t   cnt_d [NUM_REQ];

  idx_t   pick_idx;
  logic   pick_found;
  logic   release_req;
  logic   timeout;

  child_rr_scheduler_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_pick (
    .req_i      (bus.req),
    .last_idx_i (gnt_idx_q),
    .next_idx_o (pick_idx),
    .found_o    (pick_found)
  );

  // Strays on non-granted done bits are ignored by indexing only the owner.
  assign release_req = bus.done[gnt_idx_q] || !bus.req[gnt_idx_q];

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] hold_q, hold_d;

  assign timeout = (hold_q == HoldW'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if (state_q == StGrant && state_d == StGrant) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    revoked_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d   = StGrant;
          gnt_idx_d = pick_idx;
          gnt_d     = req_t'(1) << pick_idx;
          if (cnt_q[pick_idx] != '1) begin
            cnt_d[pick_idx] = cnt_q[pick_idx] + 1'b1;
          end
        end
      end
      StGrant: begin
        if (release_req) begin
          state_d = StRelease;
          gnt_d   = '0;
        end else if (timeout) begin
          state_d   = StRelease;
          gnt_d     = '0;
          revoked_d = 1'b1;
        end
      end
      StRelease: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= idx_t'(NUM_REQ - 1);
      revoked_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      revoked_q   <= revoked_d;
      cnt_q       <= cnt_d;
    end
  end

  logic [NUM_REQ*CNT_W-1:0] cnt_flat;

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.revoked   = revoked_q;
  assign bus.gnt_cnt   = cnt_flat;

endmodule

// File: tb/tb_child_rr_scheduler.sv
// Self-checking bench for child_rr_scheduler: directed scenarios plus random traffic vs a reference.
module tb_child_rr_scheduler;

  localparam int N       = 5;
  localparam int CntW    = 8;
  localparam int MaxHold = 16;
  localparam int CntMax  = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_v  = '0;
  logic [N-1:0] done_v = '0;

  int nvec = 0;
  int nerr = 0;

  // Reference: owner (-1 = none), turnaround gap, last winner, hold age, grant counts.
  int owner = -1;
  int last  = N - 1;
  int gap   = 0;
  int hold  = 0;
  int cnt [N];
  bit exp_rev = 1'b0;

  child_rr_scheduler_if #(.NUM_REQ(N), .CNT_W(CntW)) bus ();

  assign bus.req  = req_v;
  assign bus.done = done_v;

  child_rr_scheduler #(
    .NUM_REQ  (N),
    .MAX_HOLD (MaxHold),
    .CNT_W    (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_edge();
    bit found;
    exp_rev = 1'b0;
    if (rst) begin
      owner = -1;
      last  = N - 1;
      gap   = 0;
      hold  = 0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      return;
    end
    if (owner >= 0) begin
      if (done_v[owner] || !req_v[owner]) begin
        owner = -1;
        gap   = 1;
      end
`ifdef SCHED_TIMEOUT_EN
      else if (hold == MaxHold - 1) begin
        owner   = -1;
        gap     = 1;
        exp_rev = 1'b1;
      end
`endif
      else begin
        hold++;
      end
    end else if (gap > 0) begin
      gap--;
    end else if (req_v != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (!found && req_v[c]) begin
          found = 1'b1;
          owner = c;
        end
      end
      last = owner;
      hold = 0;
      if (cnt[owner] < CntMax) cnt[owner]++;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0]      eg;
    logic [N*CntW-1:0] ec;
    eg = (owner >= 0) ? (N'(1) << owner) : '0;
    ec = '0;
    for (int i = 0; i < N; i++) ec[i*CntW +: CntW] = CntW'(cnt[i]);
    chk("gnt", 64'(bus.gnt), 64'(eg));
    chk("gnt_valid", 64'(bus.gnt_valid), 64'(owner >= 0));
    chk("gnt_idx", 64'(bus.gnt_idx), 64'(last));
    chk("revoked", 64'(bus.revoked), 64'(exp_rev));
    chk("gnt_cnt", 64'(bus.gnt_cnt), 64'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_v  = '0;
    done_v = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int budget, output int idx);
    idx = -1;
    for (int i = 0; i < budget && idx < 0; i++) begin
      step();
      if (bus.gnt_valid) idx = int'(bus.gnt_idx);
    end
    nvec++;
    assert (idx >= 0)
    else begin
      nerr++;
      $error("FAIL grant_wait observed=none expected=grant within %0d cycles", budget);
    end
  endtask

  task automatic pulse_done(input int i);
    done_v = N'(1) << i;
    step();
    done_v = '0;
  endtask

  initial begin
    int idx;
    int order [6];
    int exp_order [6] = '{0, 1, 2, 3, 4, 0};

    // Reset values
    do_reset();
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_idx", 64'(bus.gnt_idx), 64'(N - 1));
    chk("rst_cnt", 64'(bus.gnt_cnt), 64'(0));

    // Single requester: grant visible one cycle after req
    req_v = 5'b00100;
    step();
    chk("single_gnt", 64'(bus.gnt), 64'(5'b00100));
    chk("single_idx", 64'(bus.gnt_idx), 64'(2));
    chk("single_cnt2", 64'(bus.gnt_cnt[2*CntW +: CntW]), 64'(1));

    // Rotation with all requesting, done 3 cycles into each grant
    do_reset();
    req_v = 5'b11111;
    for (int g = 0; g < 6; g++) begin
      wait_grant(8, idx);
      order[g] = idx;
      step();
      step();
      if (idx >= 0) pulse_done(idx);
    end
    for (int g = 0; g < 6; g++) chk($sformatf("rot_order%0d", g), 64'(order[g]), 64'(exp_order[g]));

    // Wrap: after idx 4 releases, 0 wins over 4
    do_reset();
    req_v = 5'b10000;
    wait_grant(4, idx);
    chk("wrap_first", 64'(idx), 64'(4));
    pulse_done(4);
    req_v = 5'b10001;
    wait_grant(4, idx);
    chk("wrap_next", 64'(idx), 64'(0));

    // Stray done ignored; owner's done releases
    do_reset();
    req_v = 5'b00010;
    wait_grant(4, idx);
    done_v = 5'b01000;
    step();
    done_v = '0;
    chk("stray_hold", 64'(bus.gnt), 64'(5'b00010));
    pulse_done(1);
    chk("release_gnt", 64'(bus.gnt), 64'(0));
    step();
    chk("idle_gnt", 64'(bus.gnt), 64'(0));

    // Reset while granted
    do_reset();
    req_v = 5'b00010;
    wait_grant(4, idx);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_gnt", 64'(bus.gnt), 64'(0));
    chk("rstmid_cnt", 64'(bus.gnt_cnt), 64'(0));
    chk("rstmid_idx", 64'(bus.gnt_idx), 64'(4));
    chk("rstmid_rev", 64'(bus.revoked), 64'(0));

    // Counter saturation on slot 0
    do_reset();
    req_v = 5'b00001;
    for (int g = 0; g < CntMax + 4; g++) begin
      wait_grant(6, idx);
      pulse_done(0);
    end
    chk("sat_cnt0", 64'(bus.gnt_cnt[0 +: CntW]), 64'(CntMax));

`ifdef SCHED_TIMEOUT_EN
    // Forced revoke after MaxHold cycles of grant
    do_reset();
    req_v = 5'b01000;
    wait_grant(4, idx);
    for (int i = 0; i < MaxHold; i++) step();
    chk("timeout_rev", 64'(bus.revoked), 64'(1));
`endif

    // Random traffic against the reference
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req_v[b] = ~req_v[b];
      end
      done_v = N'($urandom) & N'($urandom);
      if ($urandom_range(99) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
